wasm_linear_memory: RTL and testbench

- Parametrised successor to the word memory: a byte-addressed, little-endian linear memory for the WASM core.
- Supports 8/16/32-bit loads and stores at any byte address. Loads are zero- or sign-extended.
- Unaligned accesses that cross a word boundary take two cycles. Out-of-bounds accesses raise an error response.
- Sits between the interpreter's load/store unit and on-chip RAM.

---
 rtl/wasm_mem_pkg.sv | 27 ++
 rtl/wasm_mem_lane_align.sv | 52 +++++
 rtl/wasm_linear_memory.sv | 181 ++++++++++++++++++
 tb/tb_wasm_linear_memory.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wasm_mem_pkg.sv
// Shared encodings and helpers for the WASM byte-addressed linear memory.
package wasm_mem_pkg;

  localparam logic [1:0] SZ_8   = 2'b00;
  localparam logic [1:0] SZ_16  = 2'b01;
  localparam logic [1:0] SZ_32  = 2'b10;
  localparam logic [1:0] SZ_BAD = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t CHECK  = 2'd1;
  localparam state_t SECOND = 2'd2;

  // Number of bytes touched by an access; reserved encoding touches none.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_8:    n = 3'd1;
      SZ_16:   n = 3'd2;
      SZ_32:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wasm_mem_lane_align.sv
// Byte-lane steering for the linear memory: write masks/data for the two words an access may
// touch, and little-endian merge plus zero/sign extension of load data.
module wasm_mem_lane_align
  import wasm_mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] first_word,
  input  logic [31:0] second_word,
  output logic [3:0]  be_first,
  output logic [3:0]  be_second,
  output logic [31:0] wdata_first,
  output logic [31:0] wdata_second,
  output logic [31:0] rdata
);

  logic [3:0]  lane_mask;
  logic [7:0]  mask_wide;
  logic [63:0] data_wide;
  logic [63:0] merged;
  logic [31:0] raw;

  always_comb begin
    lane_mask = 4'b0000;
    case (size)
      SZ_8:    lane_mask = 4'b0001;
      SZ_16:   lane_mask = 4'b0011;
      SZ_32:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase

    // Treat the two words as one 64-bit window so crossing accesses fall out of a plain shift.
    mask_wide    = {4'b0000, lane_mask} << offset;
    data_wide    = {32'h0, wdata} << {offset, 3'b000};
    be_first     = mask_wide[3:0];
    be_second    = mask_wide[7:4];
    wdata_first  = data_wide[31:0];
    wdata_second = data_wide[63:32];

    merged = {second_word, first_word} >> {offset, 3'b000};
    raw    = merged[31:0];
    case (size)
      SZ_8:    rdata = {{24{is_signed & raw[7]}}, raw[7:0]};
      SZ_16:   rdata = {{16{is_signed & raw[15]}}, raw[15:0]};
      SZ_32:   rdata = raw;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/wasm_linear_memory.sv
// Byte-addressed little-endian linear memory with 8/16/32-bit accesses, two-cycle crossing
// accesses and bounds errors. Define WASM_MEM_INIT_EN to add the INIT_FILE parameter.
module wasm_linear_memory
  import wasm_mem_pkg::*;
#(
  parameter int unsigned WORDS  = 2048,
  parameter int unsigned ADDR_W = 32
`ifdef WASM_MEM_INIT_EN
  ,
  parameter string INIT_FILE = "mem_init.hex"
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_size,
  input  logic              cmd_signed,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata
);

  localparam int unsigned     IDX_W     = $clog2(WORDS);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(64'(WORDS) * 64'd4);

  logic [31:0] mem [WORDS];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       save_q, save_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic [31:0]      rd_q;
  logic [IDX_W-1:0] idx_q, idx_next, cmd_idx, rd_idx;
  logic [ADDR_W:0]  end_addr;
  logic             err, crossing;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  logic [3:0]  be_first, be_second;
  logic [31:0] wd_first, wd_second, lane_rdata, first_word;

  assign idx_q    = addr_q[IDX_W+1:2];
  assign idx_next = idx_q + IDX_W'(1);
  assign cmd_idx  = cmd_addr[IDX_W+1:2];

  // Extra top bit keeps addr+bytes from wrapping near the top of the address space.
  assign end_addr = {1'b0, addr_q} + (ADDR_W + 1)'(size_bytes(size_q));
  assign err      = (size_q == SZ_BAD) || (end_addr > MEM_BYTES);
  assign crossing = ({2'b00, addr_q[1:0]} + {1'b0, size_bytes(size_q)}) > 4'd4;

  // Synchronous read: the first word is fetched on the accept edge, the second in CHECK.
  assign rd_idx     = (state_q == IDLE) ? cmd_idx : idx_next;
  assign first_word = (state_q == SECOND) ? save_q : rd_q;

  wasm_mem_lane_align u_lane_align (
    .offset       (addr_q[1:0]),
    .size         (size_q),
    .is_signed    (signed_q),
    .wdata        (wdata_q),
    .first_word   (first_word),
    .second_word  (rd_q),
    .be_first     (be_first),
    .be_second    (be_second),
    .wdata_first  (wd_first),
    .wdata_second (wd_second),
    .rdata        (lane_rdata)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    signed_d     = signed_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    save_d       = save_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    wr_en        = 1'b0;
    wr_idx       = idx_q;
    wr_be        = be_first;
    wr_data      = wd_first;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          size_d   = cmd_size;
          signed_d = cmd_signed;
          write_d  = cmd_write;
          wdata_d  = cmd_wdata;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (err) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h0;
          state_d      = IDLE;
        end else begin
          wr_en = write_q;
          if (crossing) begin
            save_d  = rd_q;
            state_d = SECOND;
          end else begin
            resp_valid_d = 1'b1;
            resp_rdata_d = write_q ? 32'h0 : lane_rdata;
            state_d      = IDLE;
          end
        end
      end
      SECOND: begin
        wr_en        = write_q;
        wr_idx       = idx_next;
        wr_be        = be_second;
        wr_data      = wd_second;
        resp_valid_d = 1'b1;
        resp_rdata_d = write_q ? 32'h0 : lane_rdata;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= SZ_8;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= 32'h0;
      save_q       <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      save_q       <= save_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    rd_q <= mem[rd_idx];
  end

  assign cmd_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_wasm_linear_memory.sv
// Scoreboard bench for wasm_linear_memory: a byte-array model predicts every response and latency.
module tb_wasm_linear_memory;

  localparam int WORDS = 64;
  localparam int MEMB  = 4 * WORDS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic        cmd_signed;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  wasm_linear_memory #(
    .WORDS  (WORDS),
    .ADDR_W (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_size   (cmd_size),
    .cmd_signed (cmd_signed),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned acc;
    int unsigned lat;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  byte unsigned model[MEMB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: memory is an array of bytes; an access touches bytes addr..addr+n-1.
  task automatic model_access(input logic wr, input logic [1:0] sz, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic err, output logic [31:0] rd,
                              output int unsigned lat);
    int unsigned n;
    longint unsigned last;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    last = longint'({32'h0, addr}) + longint'(n);
    err  = (sz == 2'd3) || (last > longint'(MEMB));
    rd   = 32'h0;
    lat  = 1;
    if (!err) begin
      lat = ((addr % 4) + n > 4) ? 2 : 1;
      for (int i = 0; i < int'(n); i++) begin
        if (wr) model[int'(addr) + i] = wd[8*i +: 8];
        else    rd = rd | (32'(model[int'(addr) + i]) << (8 * i));
      end
      if (!wr && sgn && n == 1 && rd[7])  rd = rd | 32'hFFFF_FF00;
      if (!wr && sgn && n == 2 && rd[15]) rd = rd | 32'hFFFF_0000;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got resp at edge %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_err"}, 32'(resp_err), 32'(e.err));
        check({e.name, "_rdata"}, resp_rdata, e.rdata);
        check({e.name, "_latency"}, cyc - e.acc, e.lat);
      end
    end
  end

  // Called at a negedge; leaves cmd_valid high so consecutive calls are back-to-back.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit use_const = 1'b0, input logic [31:0] cexp = 32'h0,
                       input logic cerr = 1'b0, input string name = "rand");
    exp_t e;
    int   w;
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_size   = sz;
    cmd_signed = sgn;
    cmd_addr   = addr;
    cmd_wdata  = wd;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout %s: got cmd_ready=0 for 50 cycles, expected 1", name);
      cmd_valid = 1'b0;
      return;
    end
    model_access(wr, sz, sgn, addr, wd, e.err, e.rdata, e.lat);
    if (use_const) begin
      e.rdata = cexp;
      e.err   = cerr;
    end
    e.acc  = cyc + 1;
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int w;
    idle(1);
    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_size   = 2'd0;
    cmd_signed = 1'b0;
    cmd_addr   = 32'h0;
    cmd_wdata  = 32'h0;
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int w = 0; w < WORDS; w++) issue(1'b1, 2'd2, 1'b0, 32'(4 * w), 32'h0);

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, "st32_aligned");
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, "ld32_aligned");
    idle(2);
    issue(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0000_00EF, 1'b0, "ld8_u_10");
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 32'hFFFF_FFDE, 1'b0, "ld8_s_13");
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0000_00DE, 1'b0, "ld8_u_13");
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1, 32'hFFFF_DEAD, 1'b0, "ld16_s_12");
    issue(1'b1, 2'd2, 1'b0, 32'h0E, 32'h1122_3344, 1'b1, 32'h0, 1'b0, "st32_cross");
    issue(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 1'b1, 32'h3344_0000, 1'b0, "ld32_0c");
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_1122, 1'b0, "ld32_10");
    issue(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, 1'b1, 32'h1122_3344, 1'b0, "ld32_cross");
    idle(1);
    issue(1'b0, 2'd2, 1'b0, 32'(MEMB - 2), 32'h0, 1'b1, 32'h0, 1'b1, "ld32_oob");
    issue(1'b1, 2'd0, 1'b0, 32'(MEMB - 1), 32'h0000_00A5, 1'b1, 32'h0, 1'b0, "st8_last");
    issue(1'b0, 2'd0, 1'b0, 32'(MEMB - 1), 32'h0, 1'b1, 32'h0000_00A5, 1'b0, "ld8_last");
    issue(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0, 1'b1, "size_bad");
    issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, "ld_wrap");
    issue(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF, 1'b1, 32'h0, 1'b1, "st_wrap");
    issue(1'b1, 2'd0, 1'b0, 32'(MEMB), 32'h77, 1'b1, 32'h0, 1'b1, "st8_oob");
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, "ld32_0_intact");

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, MEMB + 3));
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    drain("random");

    issue(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, 1'b0, 32'h0, 1'b0, "ld_aborted");
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_valid", 32'(resp_valid), 32'd0);
    check("midrst_err", 32'(resp_err), 32'd0);
    check("midrst_rdata", resp_rdata, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, 1'b0, 32'h0, 1'b0, "post_rst_cross");
    issue(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, 1'b0, 32'h0, 1'b0, "post_rst_ld16");
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
